axi4_frame_reader: RTL and testbench

//  AXI4 read master that fetches one full video frame from DDR (the buffer filled by the
//  AXI4 writer) in fixed-length INCR bursts and streams the 64-bit beats to the display-side

---
 rtl/axi4_frame_reader.sv | 176 +++++++++++++++++
 tb/tb_axi4_frame_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_reader.sv
// -----------------------------------------------------------------------------
// axi4_frame_reader
//   AXI4 read master that pulls one complete video frame out of DDR as a
//   sequence of fixed-length INCR bursts and streams each 64-bit beat to the
//   display-side read FIFO. Only one read burst is in flight at a time.
//
// Ports
//   clk_100Mhz, rst     : clock (rising edge) and async active-high reset
//   frame_start         : 1-cycle pulse, starts a frame when idle
//   FRAME_BASE_ADDR     : 4 KB aligned frame base, latched on accepted start
//   i_prog_full         : downstream FIFO cannot take another full burst
//   AR* / R*            : AXI4 read address / read data channels
//   out_data, out_valid : beat and write strobe toward the FIFO
//   frame_busy          : high while a frame is being fetched
//   frame_end           : 1-cycle pulse after the last burst completes
//   rd_err              : sticky error (bad RRESP or RLAST/beat mismatch)
//   state, ADDR_OFFSET  : debug view of the FSM and current burst offset
// -----------------------------------------------------------------------------
module axi4_frame_reader #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int BURST_LEN      = 16,
   parameter int FRAME_BYTES    = 614400
) (
   input  logic                      clk_100Mhz,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
   input  logic                      i_prog_full,
   output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   output logic [7:0]                ARLEN,
   output logic [2:0]                ARSIZE,
   output logic [1:0]                ARBURST,
   output logic [3:0]                ARCACHE,
   output logic [2:0]                ARPROT,
   input  logic [AXI_DATA_WIDTH-1:0] RDATA,
   input  logic                      RVALID,
   output logic                      RREADY,
   input  logic                      RLAST,
   input  logic [1:0]                RRESP,
   output logic [AXI_DATA_WIDTH-1:0] out_data,
   output logic                      out_valid,
   output logic                      frame_busy,
   output logic                      frame_end,
   output logic                      rd_err,
   output logic [1:0]                state,
   output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

   localparam int BURST_BYTES = BURST_LEN * (AXI_DATA_WIDTH / 8);
   localparam int CNT_W       = $clog2(BURST_LEN + 1);

   localparam logic [CNT_W-1:0]          LAST_IDX   = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]          CNT_MAX    = CNT_W'(BURST_LEN);
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STEP = AXI_ADDR_WIDTH'(BURST_BYTES);
   // Offset of the final burst; reaching it in NEXT means the frame is done.
   localparam logic [AXI_ADDR_WIDTH-1:0] LAST_OFF   = AXI_ADDR_WIDTH'(FRAME_BYTES - BURST_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_NEXT = 2'd3
   } state_t;

   state_t                    r_state;
   logic [AXI_ADDR_WIDTH-1:0] r_base;
   logic [AXI_ADDR_WIDTH-1:0] r_offset;
   logic [AXI_ADDR_WIDTH-1:0] r_araddr;
   logic                      r_arvalid;
   logic                      r_rready;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [AXI_DATA_WIDTH-1:0] r_out_data;
   logic                      r_out_valid;
   logic                      r_frame_busy;
   logic                      r_frame_end;
   logic                      r_rd_err;
   logic                      w_beat;

   assign w_beat = RVALID && r_rready;

   always_ff @(posedge clk_100Mhz or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_base       <= '0;
         r_offset     <= '0;
         r_araddr     <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_beat_cnt   <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_frame_busy <= 1'b0;
         r_frame_end  <= 1'b0;
         r_rd_err     <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_frame_end <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_base       <= FRAME_BASE_ADDR;
                  r_offset     <= '0;
                  r_rd_err     <= 1'b0;
                  r_frame_busy <= 1'b1;
                  r_state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               // i_prog_full only gates issuing; a presented AR is never withdrawn.
               if (!r_arvalid) begin
                  if (!i_prog_full) begin
                     r_arvalid <= 1'b1;
                     r_araddr  <= r_base + r_offset;
                  end
               end else if (ARREADY) begin
                  r_arvalid  <= 1'b0;
                  r_rready   <= 1'b1;
                  r_beat_cnt <= '0;
                  r_state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_out_data  <= RDATA;
                  r_out_valid <= 1'b1;
                  if (RRESP != 2'b00)
                     r_rd_err <= 1'b1;
                  if (r_beat_cnt != CNT_MAX)
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (RLAST) begin
                     r_rready <= 1'b0;
                     r_state  <= S_NEXT;
                     if (r_beat_cnt != LAST_IDX)
                        r_rd_err <= 1'b1;
                  end else if (r_beat_cnt >= LAST_IDX) begin
                     // Full burst length seen without RLAST: flag it, keep draining.
                     r_rd_err <= 1'b1;
                  end
               end
            end
            S_NEXT: begin
               if (r_offset == LAST_OFF) begin
                  r_offset     <= '0;
                  r_frame_end  <= 1'b1;
                  r_frame_busy <= 1'b0;
                  r_state      <= S_IDLE;
               end else begin
                  r_offset <= r_offset + BURST_STEP;
                  r_state  <= S_ADDR;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ARADDR      = r_araddr;
   assign ARVALID     = r_arvalid;
   assign ARLEN       = 8'(BURST_LEN - 1);
   assign ARSIZE      = 3'b011;
   assign ARBURST     = 2'b01;
   assign ARCACHE     = 4'b0011;
   assign ARPROT      = 3'b000;
   assign RREADY      = r_rready;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign frame_busy  = r_frame_busy;
   assign frame_end   = r_frame_end;
   assign rd_err      = r_rd_err;
   assign state       = r_state;
   assign ADDR_OFFSET = r_offset;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_axi4_frame_reader
//   Directed bench for axi4_frame_reader with a 3-burst (384 B) frame. A
//   behavioural AXI read slave answers each AR with beats whose data is
//   {burst address, beat index}; expected ARs and beats are queued when a
//   frame is launched and a monitor pops and compares them as they appear.
// -----------------------------------------------------------------------------
module tb_axi4_frame_reader;

   localparam int FB = 384;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [31:0] FRAME_BASE_ADDR = '0;
   logic        i_prog_full = 1'b0;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [3:0]  ARCACHE;
   logic [2:0]  ARPROT;
   logic [63:0] RDATA;
   logic        RVALID;
   logic        RREADY;
   logic        RLAST;
   logic [1:0]  RRESP;
   logic [63:0] out_data;
   logic        out_valid;
   logic        frame_busy;
   logic        frame_end;
   logic        rd_err;
   logic [1:0]  state;
   logic [31:0] ADDR_OFFSET;

   always #5 clk = ~clk;

   axi4_frame_reader #(.FRAME_BYTES(FB)) dut (
      .clk_100Mhz(clk), .rst(rst), .frame_start(frame_start),
      .FRAME_BASE_ADDR(FRAME_BASE_ADDR), .i_prog_full(i_prog_full),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARCACHE(ARCACHE),
      .ARPROT(ARPROT), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
      .RLAST(RLAST), .RRESP(RRESP), .out_data(out_data), .out_valid(out_valid),
      .frame_busy(frame_busy), .frame_end(frame_end), .rd_err(rd_err),
      .state(state), .ADDR_OFFSET(ADDR_OFFSET)
   );

   int          errors = 0;
   int          checks = 0;
   int          beats_seen = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_ar[$];

   // slave behaviour knobs
   logic [31:0] cfg_base = '0;
   int          ar_delay = 0;
   int          rv_on = 1;
   int          rv_off = 0;
   int          err_bidx = -1;
   int          err_beat = 0;
   int          short_bidx = -1;
   int          short_n = 16;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // AXI read slave: decisions at negedge, transfers happen on the next posedge.
   initial begin : slave
      int          phase, arcnt, beat, gcnt, bidx, last_idx;
      logic        pend_ar, pend_r;
      logic [31:0] lat_addr, cur_addr;
      phase = 0; arcnt = 0; beat = 0; gcnt = 0; bidx = 0; last_idx = 15;
      pend_ar = 1'b0; pend_r = 1'b0; lat_addr = '0; cur_addr = '0;
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RDATA = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            phase = 0; arcnt = 0; pend_ar = 1'b0; pend_r = 1'b0;
         end else begin
            if (pend_r) begin
               if (RLAST) phase = 0;
               beat++;
            end
            if (pend_ar) begin
               phase = 1; cur_addr = lat_addr; beat = 0; gcnt = 0;
            end
            if (phase == 0 && ARVALID) begin
               if (arcnt >= ar_delay) ARREADY = 1'b1;
               else begin ARREADY = 1'b0; arcnt++; end
            end else begin
               ARREADY = 1'b0; arcnt = 0;
            end
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            if (phase == 1) begin
               bidx = int'((cur_addr - cfg_base) >> 7);
               last_idx = (bidx == short_bidx) ? short_n - 1 : 15;
               if ((gcnt % (rv_on + rv_off)) < rv_on) begin
                  RVALID = 1'b1;
                  RDATA  = {cur_addr, 32'(beat)};
                  RLAST  = (beat == last_idx);
                  RRESP  = (bidx == err_bidx && beat == err_beat) ? 2'b10 : 2'b00;
               end
               gcnt++;
            end
            pend_ar  = ARVALID && ARREADY;
            lat_addr = ARADDR;
            pend_r   = RVALID && RREADY;
         end
      end
   end

   // Scoreboard monitor: beats, AR addresses, AR hold-while-stalled.
   initial begin : monitor
      logic        hold_v;
      logic [31:0] hold_a;
      hold_v = 1'b0; hold_a = '0;
      forever begin
         @(negedge clk);
         if (rst) hold_v = 1'b0;
         else begin
            if (out_valid) begin
               beats_seen++;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_beat: got %h expected no beat", out_data);
               end else chk("beat_data", out_data, exp_q.pop_front());
            end
            if (hold_v) begin
               chk("arvalid_hold", 64'(ARVALID), 64'(1));
               chk("araddr_hold", 64'(ARADDR), 64'(hold_a));
            end
            if (ARVALID && ARREADY) begin
               if (exp_ar.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_ar: got %h expected no AR", ARADDR);
               end else chk("araddr", 64'(ARADDR), 64'(exp_ar.pop_front()));
            end
            hold_v = ARVALID && !ARREADY;
            hold_a = ARADDR;
         end
      end
   end

   task automatic push_frame(input logic [31:0] base);
      logic [31:0] a;
      int          n;
      for (int b = 0; b < FB / 128; b++) begin
         a = base + 32'(b * 128);
         n = (b == short_bidx) ? short_n : 16;
         exp_ar.push_back(a);
         for (int k = 0; k < n; k++) exp_q.push_back({a, 32'(k)});
      end
   endtask

   task automatic start_frame(input logic [31:0] base);
      cfg_base   = base;
      beats_seen = 0;
      push_frame(base);
      @(negedge clk);
      frame_start = 1'b1; FRAME_BASE_ADDR = base;
      @(negedge clk);
      frame_start = 1'b0;
      chk("frame_busy_set", 64'(frame_busy), 64'(1));
      chk("rd_err_cleared", 64'(rd_err), 64'(0));
   endtask

   task automatic wait_frame_end(input int budget);
      int         n_end;
      logic [1:0] prev;
      n_end = 0; prev = 2'd0;
      for (int c = 0; c < budget && n_end == 0; c++) begin
         @(negedge clk);
         if (frame_end) begin
            n_end++;
            chk("frame_end_after_next", 64'(prev), 64'(3));
         end
         prev = state;
      end
      chk("frame_end_seen", 64'(n_end), 64'(1));
      @(negedge clk);
      chk("frame_end_pulse", 64'(frame_end), 64'(0));
      chk("frame_busy_clear", 64'(frame_busy), 64'(0));
      chk("beats_drained", 64'(exp_q.size()), 64'(0));
      chk("ars_drained", 64'(exp_ar.size()), 64'(0));
   endtask

   task automatic clean_cfg();
      ar_delay = 0; rv_on = 1; rv_off = 0;
      err_bidx = -1; err_beat = 0; short_bidx = -1; short_n = 16;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctrl"},
          64'({state, ARVALID, RREADY, out_valid, frame_busy, frame_end, rd_err}), 64'(0));
      chk({tag, "_out_data"}, out_data, 64'(0));
      chk({tag, "_araddr"}, 64'(ARADDR), 64'(0));
      chk({tag, "_offset"}, 64'(ADDR_OFFSET), 64'(0));
   endtask

   initial begin : stim
      logic any_ar;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      chk("ar_consts", 64'({ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT}),
          64'({8'd15, 3'b011, 2'b01, 4'b0011, 3'b000}));
      rst = 1'b0;

      // 1: back-to-back slave, continuous data
      clean_cfg();
      start_frame(32'h1000_0000);
      wait_frame_end(500);
      chk("t1_beats", 64'(beats_seen), 64'(48));
      chk("t1_rd_err", 64'(rd_err), 64'(0));

      // 2: ARREADY delayed 5 cycles per burst
      clean_cfg(); ar_delay = 5;
      start_frame(32'h2000_3000);
      wait_frame_end(800);
      chk("t2_beats", 64'(beats_seen), 64'(48));

      // 3: prog_full back-pressure on AR issue
      clean_cfg(); ar_delay = 5;
      i_prog_full = 1'b1;
      start_frame(32'h1000_0000);
      any_ar = 1'b0;
      repeat (20) begin
         @(negedge clk);
         any_ar = any_ar | ARVALID;
      end
      chk("t3_ar_blocked", 64'(any_ar), 64'(0));
      i_prog_full = 1'b0;
      @(negedge clk);
      chk("t3_ar_after_release", 64'(ARVALID), 64'(1));
      i_prog_full = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_ar_stays", 64'(ARVALID), 64'(1));
      end
      repeat (40) @(negedge clk);
      chk("t3_ar_blocked_b1", 64'(ARVALID), 64'(0));
      chk("t3_state_addr", 64'(state), 64'(1));
      i_prog_full = 1'b0;
      wait_frame_end(800);

      // 4: RVALID 1 on / 2 off
      clean_cfg(); rv_on = 1; rv_off = 2;
      start_frame(32'h4000_0000);
      wait_frame_end(1000);
      chk("t4_beats", 64'(beats_seen), 64'(48));

      // 5a: SLVERR on beat 3 of burst 0
      clean_cfg(); err_bidx = 0; err_beat = 3;
      start_frame(32'h1000_0000);
      wait_frame_end(500);
      chk("t5a_rd_err", 64'(rd_err), 64'(1));
      // 5b: clean frame clears it
      clean_cfg();
      start_frame(32'h1000_0000);
      wait_frame_end(500);
      chk("t5b_rd_err", 64'(rd_err), 64'(0));
      // 5c: early RLAST on beat 9 of burst 1
      clean_cfg(); short_bidx = 1; short_n = 10;
      start_frame(32'h1000_0000);
      wait_frame_end(500);
      chk("t5c_beats", 64'(beats_seen), 64'(42));
      chk("t5c_rd_err", 64'(rd_err), 64'(1));
      // 5d: RLAST late (18 beats) on burst 2
      clean_cfg(); short_bidx = 2; short_n = 18;
      start_frame(32'h1000_0000);
      wait_frame_end(500);
      chk("t5d_beats", 64'(beats_seen), 64'(50));
      chk("t5d_rd_err", 64'(rd_err), 64'(1));

      // 6: reset mid-burst
      clean_cfg(); err_bidx = 0; err_beat = 2;
      start_frame(32'h3000_0000);
      for (int c = 0; c < 200 && beats_seen < 7; c++) @(negedge clk);
      chk("t6_beats_before_rst", 64'(beats_seen), 64'(7));
      chk("t6_state_data", 64'(state), 64'(2));
      chk("t6_rd_err_before", 64'(rd_err), 64'(1));
      #2 rst = 1'b1;
      #1 chk_reset_outs("t6_rst");
      exp_q.delete(); exp_ar.delete();
      clean_cfg();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_frame(32'h3000_0000);
      wait_frame_end(500);
      chk("t6_beats_after", 64'(beats_seen), 64'(48));
      chk("t6_rd_err_after", 64'(rd_err), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
